// File: rtl/dly_arb_pkg.sv
// Shared types and constants for the dly_arb settle-delay scheduler.
package dly_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    localparam int DEFAULT_DELAY_CYCLES = 25_000_000;

    // Requester-id width; a single requester still needs one bit.
    function automatic int ID_W(input int n);
        if (n <= 1) return 1;
        else        return $clog2(n);
    endfunction

endpackage

// File: rtl/dly_arb_if.sv
// Requester-side bundle of dly_arb: level-sampled request/abort in, done pulses and status out.
interface dly_arb_if
    import dly_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int IW = ID_W(NUM_REQ);

    // Protocol: req_i/abort_i are sampled on every posedge (each high cycle counts, no
    // ready/ack); done_o is a single-cycle pulse, at most one bit high per cycle.
    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] abort_i;
    logic [NUM_REQ-1:0] done_o;
    logic [NUM_REQ-1:0] pending_o;
    logic               busy_o;
    logic [IW-1:0]      active_id_o;

    modport master (
        output req_i, abort_i,
        input  done_o, pending_o, busy_o, active_id_o
    );

    modport slave (
        input  req_i, abort_i,
        output done_o, pending_o, busy_o, active_id_o
    );

endinterface

// File: rtl/dly_arb_rr_pick.sv
// Combinational grant picker: round-robin from ptr_i+1, or lowest index when
// DLY_ARB_FIXED_PRIO_EN is defined.
module dly_rr_pick
    import dly_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = ID_W(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [IW-1:0]      ptr_i,
    output logic               grant_valid_o,
    output logic [IW-1:0]      grant_id_o
);

`ifdef DLY_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        grant_valid_o = 1'b0;
        grant_id_o    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pending_i[i]) begin
                grant_valid_o = 1'b1;
                grant_id_o    = IW'(i);
            end
        end
    end
`else
    always_comb begin
        int idx;
        idx           = 0;
        grant_valid_o = 1'b0;
        grant_id_o    = '0;
        // Walk offsets from farthest to nearest so the nearest set bit after ptr_i wins.
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(ptr_i) + off) % NUM_REQ;
            if (pending_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_id_o    = IW'(idx);
            end
        end
    end
`endif

endmodule

// File: rtl/dly_arb.sv
// Shared settle-delay scheduler: queues per-requester delay requests and times them on one
// counter. Define DLY_ARB_FIXED_PRIO_EN for fixed (lowest-index) priority instead of round-robin.
module dly_arb
    import dly_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CNT_W        = 26,
    parameter int DELAY_CYCLES = DEFAULT_DELAY_CYCLES
) (
    input  logic     clk,
    input  logic     rst_n,
    dly_arb_if.slave bus,
    output state_e   dbg_state_o
);

    localparam int IW = ID_W(NUM_REQ);

    if (DELAY_CYCLES < 1) begin : g_bad_delay
        $error("dly_arb: DELAY_CYCLES must be >= 1");
    end
    if ((64'd1 << CNT_W) <= 64'(DELAY_CYCLES)) begin : g_bad_cnt_w
        $error("dly_arb: CNT_W too narrow for DELAY_CYCLES");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [IW-1:0]      active_q, active_d;
    logic [IW-1:0]      last_q, last_d;

    logic               grant_valid;
    logic [IW-1:0]      grant_id;
    logic               grant;
    logic               act_abort;
    logic               act_req;
    logic               cnt_last;

    dly_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .pending_i     (pending_q),
        .ptr_i         (last_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    assign grant     = (state_q == IDLE) && grant_valid;
    assign act_abort = bus.abort_i[active_q];
    assign act_req   = bus.req_i[active_q];
    assign cnt_last  = (counter_q == CNT_W'(DELAY_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            counter_q <= '0;
            pending_q <= '0;
            done_q    <= '0;
            active_q  <= '0;
            last_q    <= IW'(NUM_REQ - 1);
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            active_q  <= active_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = COUNT;
            COUNT: begin
                if (act_abort)     state_d = IDLE;
                else if (act_req)  state_d = COUNT;
                else if (cnt_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        counter_d = counter_q;
        done_d    = '0;
        active_d  = active_q;
        last_d    = last_q;
        pending_d = pending_q;

        if (grant) begin
            active_d  = grant_id;
            last_d    = grant_id;
            counter_d = '0;
        end else if (state_q == COUNT) begin
            if (act_abort) begin
                counter_d = '0;
            end else if (act_req) begin
                counter_d = '0;
            end else if (cnt_last) begin
                done_d[active_q] = 1'b1;
                counter_d        = '0;
            end else begin
                counter_d = counter_q + CNT_W'(1);
            end
        end

        // A request from the requester being timed retriggers it rather than queueing.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.abort_i[i]) begin
                pending_d[i] = 1'b0;
            end else if (grant && (grant_id == IW'(i))) begin
                pending_d[i] = 1'b0;
            end else if (bus.req_i[i] && !((state_q == COUNT) && (active_q == IW'(i)))) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    assign bus.done_o      = done_q;
    assign bus.pending_o   = pending_q;
    assign bus.busy_o      = (state_q == COUNT);
    assign bus.active_id_o = active_q;
    assign dbg_state_o     = state_q;

    a_done_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done_q));

endmodule

// File: tb/tb_dly_arb.sv
// Scoreboard bench for dly_arb with DELAY_CYCLES=10, NUM_REQ=4.
module tb_dly_arb;
  import dly_arb_pkg::*;

  localparam int N  = 4;
  localparam int DC = 10;
  localparam int CW = 26;
  localparam int W  = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dly_arb_if #(.NUM_REQ(N)) bus ();
  state_e dbg_state;

  dly_arb #(.NUM_REQ(N), .CNT_W(CW), .DELAY_CYCLES(DC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic push_done(input int e, input logic [3:0] m);
    exp_q.push_back({16'(e), m});
  endtask

  task automatic check_status(input string name, input logic [3:0] pend, input logic busy,
                              input logic [1:0] id);
    chk({name, "_pending"}, 32'(bus.pending_o), 32'(pend));
    chk({name, "_busy"}, 32'(bus.busy_o), 32'(busy));
    if (busy) chk({name, "_active_id"}, 32'(bus.active_id_o), 32'(id));
  endtask

  // Called at a negedge; the request is sampled at edge e0 and we return at the negedge after it.
  task automatic pulse_req(input logic [3:0] m, output int e0);
    e0 = edge_n + 1;
    bus.req_i = m;
    @(negedge clk);
    bus.req_i = '0;
  endtask

  task automatic wait_edge(input int t);
    while (edge_n < t) @(negedge clk);
  endtask

  // Monitor: every done pulse must match the next expected {edge, mask} entry.
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (rst_n && (bus.done_o != '0)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {12'd0, 16'(edge_n), bus.done_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_event", {12'd0, 16'(edge_n), bus.done_o}, {12'd0, e});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int e0, e1, er, ea;
    bus.req_i   = '0;
    bus.abort_i = '0;
    rst_n       = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    check_status("rst", 4'b0000, 1'b0, 2'd0);
    chk("rst_active_id", 32'(bus.active_id_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Simultaneous requests: served 0, 1, 3 with done 11 edges apart
    pulse_req(4'b1011, e0);
    push_done(e0 + 11, 4'b0001);
    push_done(e0 + 22, 4'b0010);
    push_done(e0 + 33, 4'b1000);
    check_status("sim_q", 4'b1011, 1'b0, 2'd0);
    wait_edge(e0 + 1);
    check_status("sim_g0", 4'b1010, 1'b1, 2'd0);
    wait_edge(e0 + 11);
    check_status("sim_gap", 4'b1010, 1'b0, 2'd0);
    wait_edge(e0 + 12);
    check_status("sim_g1", 4'b1000, 1'b1, 2'd1);
    wait_edge(e0 + 23);
    check_status("sim_g3", 4'b0000, 1'b1, 2'd3);
    wait_edge(e0 + 34);
    check_status("sim_end", 4'b0000, 1'b0, 2'd0);

    // Single request on requester 2
    pulse_req(4'b0100, e0);
    push_done(e0 + 11, 4'b0100);
    check_status("one_q", 4'b0100, 1'b0, 2'd0);
    wait_edge(e0 + 1);
    check_status("one_g", 4'b0000, 1'b1, 2'd2);
    wait_edge(e0 + 10);
    check_status("one_last", 4'b0000, 1'b1, 2'd2);
    wait_edge(e0 + 11);
    check_status("one_end", 4'b0000, 1'b0, 2'd0);
    wait_edge(e0 + 13);

    // Retrigger requester 1 five edges into COUNT
    pulse_req(4'b0010, e0);
    e1 = e0 + 1;
    wait_edge(e1 + 4);
    pulse_req(4'b0010, er);
    push_done(er + 10, 4'b0010);
    check_status("retrig", 4'b0000, 1'b1, 2'd1);
    wait_edge(er + 9);
    check_status("retrig_late", 4'b0000, 1'b1, 2'd1);
    wait_edge(er + 12);
    check_status("retrig_end", 4'b0000, 1'b0, 2'd0);

    // Abort active requester 0 while 2 is pending
    pulse_req(4'b0001, e0);
    e1 = e0 + 1;
    wait_edge(e1);
    pulse_req(4'b0100, e0);
    check_status("abort_pre", 4'b0100, 1'b1, 2'd0);
    wait_edge(e1 + 2);
    ea = edge_n + 1;
    bus.abort_i = 4'b0001;
    @(negedge clk);
    bus.abort_i = '0;
    check_status("abort_drop", 4'b0100, 1'b0, 2'd0);
    wait_edge(ea + 1);
    check_status("abort_next", 4'b0000, 1'b1, 2'd2);
    push_done(ea + 11, 4'b0100);
    wait_edge(ea + 13);

    // Reset in the middle of COUNT
    pulse_req(4'b1000, e0);
    wait_edge(e0 + 3);
    chk("midrst_pre_busy", 32'(bus.busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_done", 32'(bus.done_o), 32'd0);
    check_status("midrst", 4'b0000, 1'b0, 2'd0);
    chk("midrst_active_id", 32'(bus.active_id_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_hold_done", 32'(bus.done_o), 32'd0);
    end
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_status("midrst_after", 4'b0000, 1'b0, 2'd0);

    // Fairness: after serving 3, 4'b0101 grants 0 before 2
    pulse_req(4'b1000, e0);
    push_done(e0 + 11, 4'b1000);
    wait_edge(e0 + 13);
    pulse_req(4'b0101, e0);
    push_done(e0 + 11, 4'b0001);
    push_done(e0 + 22, 4'b0100);
    wait_edge(e0 + 1);
    check_status("fair_a0", 4'b0100, 1'b1, 2'd0);
    wait_edge(e0 + 12);
    check_status("fair_a2", 4'b0000, 1'b1, 2'd2);
    wait_edge(e0 + 24);

    // Just served 2; 4'b1100 separates round-robin from fixed priority
    pulse_req(4'b1100, e0);
`ifdef DLY_ARB_FIXED_PRIO_EN
    push_done(e0 + 11, 4'b0100);
    push_done(e0 + 22, 4'b1000);
    wait_edge(e0 + 1);
    check_status("fair_b_first", 4'b1000, 1'b1, 2'd2);
`else
    push_done(e0 + 11, 4'b1000);
    push_done(e0 + 22, 4'b0100);
    wait_edge(e0 + 1);
    check_status("fair_b_first", 4'b0100, 1'b1, 2'd3);
`endif
    wait_edge(e0 + 24);
    check_status("fair_b_end", 4'b0000, 1'b0, 2'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
